avsdpll_lock_det: RTL

AVSDPLL_LOCK_DET -- requirements
Module: avsdpll_lock_det

---
 rtl/avsdpll_pkg.sv | 31 +++
 rtl/avsd_sync_edge.sv | 39 +++
 rtl/avsdpll_lock_det.sv | 145 ++++++++++++++
 3 files changed

// File: rtl/avsdpll_pkg.sv
// avsdpll_pkg
// Shared definitions for the AVSDPLL lock detector: FSM state encoding,
// default parameter values and the measurement window helper.
// No ports.

package avsdpll_pkg;

  typedef enum logic [1:0] {
    ST_WAIT_FIRST = 2'd0,
    ST_ACQ        = 2'd1,
    ST_LOCKED     = 2'd2
  } lock_state_e;

  localparam int unsigned DEF_RATIO      = 8;
  localparam int unsigned DEF_TOL        = 1;
  localparam int unsigned DEF_LOCK_CNT   = 4;
  localparam int unsigned DEF_UNLOCK_CNT = 2;
  localparam int unsigned DEF_TIMEOUT    = 64;
  localparam int unsigned DEF_CNT_W      = 8;

  // Unsigned window check; the lower bound clamps at zero instead of
  // wrapping when TOL exceeds RATIO.
  function automatic logic in_window(input int unsigned meas,
                                     input int unsigned ratio,
                                     input int unsigned tol);
    int unsigned lo;
    lo = (ratio > tol) ? (ratio - tol) : 32'd0;
    return (meas >= lo) && (meas <= (ratio + tol));
  endfunction

endpackage

// File: rtl/avsd_sync_edge.sv
// avsd_sync_edge
// Brings an asynchronous level into the CLK domain through two flops, then
// registers a one-cycle rising-edge pulse.
// Ports:
//   CLK   - destination clock
//   reset - synchronous active-high reset, clears every flop
//   d     - asynchronous input level
//   q     - synchronized level (second synchronizer flop)
//   rise  - registered one-cycle pulse on a synchronized 0->1 transition

module avsd_sync_edge (
  input  logic CLK,
  input  logic reset,
  input  logic d,
  output logic q,
  output logic rise
);

  logic s1;
  logic s2;
  logic s2_d;

  always_ff @(posedge CLK) begin
    if (reset) begin
      s1   <= 1'b0;
      s2   <= 1'b0;
      s2_d <= 1'b0;
      rise <= 1'b0;
    end else begin
      s1   <= d;
      s2   <= s1;
      s2_d <= s2;
      rise <= s2 & ~s2_d;
    end
  end

  assign q = s2;

endmodule

// File: rtl/avsdpll_lock_det.sv
// avsdpll_lock_det
// Counts CLK cycles between rising edges of the reference clock and decides
// whether the PLL output runs at RATIO times REF (within +/-TOL). LOCK needs
// LOCK_CNT consecutive good periods and drops after UNLOCK_CNT consecutive bad
// ones. A REF that stays silent for TIMEOUT cycles raises REF_LOST.
// Ports:
//   CLK        - PLL output clock, only clock of the block
//   reset      - synchronous active-high reset
//   REF        - reference clock, asynchronous to CLK
//   EN         - detector enable; low holds everything except the synchronizer
//   LOCK       - lock indication
//   REF_LOST   - REF edge timeout flag, cleared by the next REF edge
//   MEAS_VALID - one-cycle pulse when MEAS is updated
//   MEAS       - last measured REF period in CLK cycles
//
// state         | meaning
// --------------+-------------------------------------------------------
// ST_WAIT_FIRST | no reference edge seen yet; next edge only starts a count
// ST_ACQ        | measuring, counting consecutive good periods toward lock
// ST_LOCKED     | locked, counting consecutive bad periods toward unlock

module avsdpll_lock_det
  import avsdpll_pkg::*;
#(
  parameter int unsigned RATIO      = DEF_RATIO,
  parameter int unsigned TOL        = DEF_TOL,
  parameter int unsigned LOCK_CNT   = DEF_LOCK_CNT,
  parameter int unsigned UNLOCK_CNT = DEF_UNLOCK_CNT,
  parameter int unsigned TIMEOUT    = DEF_TIMEOUT,
  parameter int unsigned CNT_W      = DEF_CNT_W
) (
`ifdef USE_POWER_PINS
  inout  wire              vccd1,
  inout  wire              vssd1,
`endif
  input  logic             CLK,
  input  logic             reset,
  input  logic             REF,
  input  logic             EN,
  output logic             LOCK,
  output logic             REF_LOST,
  output logic             MEAS_VALID,
  output logic [CNT_W-1:0] MEAS
);

  localparam int unsigned GOOD_W = (LOCK_CNT   > 1) ? $clog2(LOCK_CNT + 1)   : 1;
  localparam int unsigned BAD_W  = (UNLOCK_CNT > 1) ? $clog2(UNLOCK_CNT + 1) : 1;

  localparam logic [CNT_W-1:0]  TIMEOUT_V   = CNT_W'(TIMEOUT);
  localparam logic [CNT_W-1:0]  CNT_MAX     = {CNT_W{1'b1}};
  localparam logic [GOOD_W-1:0] GOOD_LAST_V = GOOD_W'(LOCK_CNT - 1);
  localparam logic [BAD_W-1:0]  BAD_LAST_V  = BAD_W'(UNLOCK_CNT - 1);

  logic              ref_rise;
  logic              ref_lvl_unused;
  lock_state_e       state;
  logic [CNT_W-1:0]  per_cnt;
  logic [GOOD_W-1:0] good_cnt;
  logic [BAD_W-1:0]  bad_cnt;
  logic              meas_good;
  logic              good_last;
  logic              bad_last;
  logic              timeout_hit;

  // The synchronizer only honours the real reset so that EN toggling does
  // not manufacture or swallow a REF edge.
  avsd_sync_edge u_sync (
    .CLK   (CLK),
    .reset (reset),
    .d     (REF),
    .q     (ref_lvl_unused),
    .rise  (ref_rise)
  );

  // The value judged is the count being captured into MEAS this cycle.
  assign meas_good   = in_window(32'(per_cnt), RATIO, TOL);
  assign good_last   = (good_cnt == GOOD_LAST_V);
  assign bad_last    = (bad_cnt == BAD_LAST_V);
  assign timeout_hit = (per_cnt == TIMEOUT_V);

  always_ff @(posedge CLK) begin
    if (reset || !EN) begin
      state      <= ST_WAIT_FIRST;
      per_cnt    <= '0;
      good_cnt   <= '0;
      bad_cnt    <= '0;
      LOCK       <= 1'b0;
      REF_LOST   <= 1'b0;
      MEAS_VALID <= 1'b0;
      MEAS       <= '0;
    end else begin
      MEAS_VALID <= 1'b0;

      // Free-running period counter; a REF edge restarts it at 1 so that the
      // value seen at the following edge equals the period in CLK cycles.
      if (ref_rise) begin
        per_cnt <= CNT_W'(1);
      end else if (per_cnt != CNT_MAX) begin
        per_cnt <= per_cnt + 1'b1;
      end

      if (state == ST_WAIT_FIRST) begin
        if (ref_rise) begin
          state    <= ST_ACQ;
          REF_LOST <= 1'b0;
        end
      end else if (ref_rise) begin
        // An edge in the timeout cycle is still a valid measurement.
        MEAS       <= per_cnt;
        MEAS_VALID <= 1'b1;
        if (state == ST_ACQ) begin
          if (!meas_good) begin
            good_cnt <= '0;
          end else if (good_last) begin
            state    <= ST_LOCKED;
            LOCK     <= 1'b1;
            good_cnt <= '0;
            bad_cnt  <= '0;
          end else begin
            good_cnt <= good_cnt + 1'b1;
          end
        end else begin
          if (meas_good) begin
            bad_cnt <= '0;
          end else if (bad_last) begin
            state    <= ST_ACQ;
            LOCK     <= 1'b0;
            good_cnt <= '0;
            bad_cnt  <= '0;
          end else begin
            bad_cnt <= bad_cnt + 1'b1;
          end
        end
      end else if (timeout_hit) begin
        state    <= ST_WAIT_FIRST;
        REF_LOST <= 1'b1;
        LOCK     <= 1'b0;
        per_cnt  <= '0;
        good_cnt <= '0;
        bad_cnt  <= '0;
      end
    end
  end

endmodule
